// File: rtl/pio_rmw_arbiter_if.sv
// Request and PIO-bus bundle for pio_rmw_arbiter. The "master" modport is the
// arbiter's view (it is the Avalon-MM master toward the PIO); "slave" is everything around it.
interface pio_rmw_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 10
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*DATA_W-1:0] req_mask;
  logic [NUM_REQ-1:0]        req_ack;

  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;

  modport master (
    input  req_valid, req_data, req_mask, pio_readdata,
    output req_ack, pio_address, pio_chipselect, pio_write_n, pio_writedata
  );

  modport slave (
    output req_valid, req_data, req_mask, pio_readdata,
    input  req_ack, pio_address, pio_chipselect, pio_write_n, pio_writedata
  );
endinterface

// File: rtl/pio_rmw_arbiter.sv
// Round-robin arbiter that lets several requesters update their own bits of PIO
// word 0 through a read-modify-write, one transaction at a time.
module pio_rmw_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  pio_rmw_arbiter_if.master   bus,
  output logic                busy,
  output logic [2:0]          grant_id
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

  state_t            state;
  state_t            next_state;
  logic [2:0]        rr_ptr;
  logic [2:0]        pick_idx;
  logic              pick_found;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] lat_mask;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] merged;
  logic              unused_readdata;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && bus.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = 3'(idx);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_found) next_state = READ;
      READ:    next_state = WRITE;
      WRITE:   next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= 3'd0;
      grant_id <= 3'd0;
      shadow   <= '0;
      lat_data <= '0;
      lat_mask <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (pick_found) begin
          grant_id <= pick_idx;
          lat_data <= bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
          lat_mask <= bus.req_mask[int'(pick_idx)*DATA_W +: DATA_W];
        end
        READ:    shadow <= bus.pio_readdata[DATA_W-1:0];
        ACK:     rr_ptr <= 3'((int'(grant_id) + 1) % NUM_REQ);
        default: ;
      endcase
    end
  end

  // Bus outputs decode only flops, so they change cleanly right after the edge.
  assign merged             = (shadow & ~lat_mask) | (lat_data & lat_mask);
  assign busy               = (state != IDLE);
  assign bus.pio_address    = 2'b00;
  assign bus.pio_chipselect = (state == READ) || (state == WRITE);
  assign bus.pio_write_n    = (state != WRITE);
  assign bus.pio_writedata  = (state == WRITE) ? 32'(merged) : 32'd0;
  assign bus.req_ack        = (state == ACK) ? (ONE_HOT_0 << grant_id) : '0;

  assign unused_readdata = ^bus.pio_readdata[31:DATA_W];

endmodule

// File: tb/tb_pio_rmw_arbiter.sv
// Randomized scoreboard bench for pio_rmw_arbiter with a behavioural PIO and a
// queue-based reference model of the round-robin read-modify-write service.
module tb_pio_rmw_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 10;

  typedef struct {
    int          idx;
    logic [31:0] wdata;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              busy;
  logic [2:0]        grant_id;
  logic [DATA_W-1:0] pio_reg;
  logic              pio_load = 1'b0;
  logic [DATA_W-1:0] pio_load_val = '0;
  logic              mon_enable = 1'b0;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  exp_t exp_wr[$];
  exp_t exp_ack[$];

  int                model_ptr = 0;
  logic [DATA_W-1:0] ref_pio = '0;
  int                rc [NUM_REQ];
  logic [DATA_W-1:0] rd [NUM_REQ];
  logic [DATA_W-1:0] rm [NUM_REQ];
  int                remaining [NUM_REQ];

  pio_rmw_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  pio_rmw_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural PIO: combinational read of word 0, write on the clock edge.
  assign bus.pio_readdata = {{(32-DATA_W){1'b0}}, pio_reg};
  always @(posedge clk) begin
    if (pio_load) pio_reg <= pio_load_val;
    else if (bus.pio_chipselect && !bus.pio_write_n && bus.pio_address == 2'b00)
      pio_reg <= bus.pio_writedata[DATA_W-1:0];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Reference model: serve every pending request in round-robin order from the
  // pointer, merging masked bits into the PIO value.
  task automatic model_round();
    int left [NUM_REQ];
    int pick;
    exp_t e;
    for (int i = 0; i < NUM_REQ; i++) left[i] = rc[i];
    for (int n = 0; n < NUM_REQ * 4; n++) begin
      pick = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (model_ptr + k) % NUM_REQ;
        if (pick < 0 && left[i] > 0) pick = i;
      end
      if (pick >= 0) begin
        ref_pio = (ref_pio & ~rm[pick]) | (rd[pick] & rm[pick]);
        e.idx   = pick;
        e.wdata = {{(32-DATA_W){1'b0}}, ref_pio};
        exp_wr.push_back(e);
        exp_ack.push_back(e);
        left[pick]--;
        model_ptr = (pick + 1) % NUM_REQ;
      end
    end
  endtask

  task automatic clear_round();
    for (int i = 0; i < NUM_REQ; i++) begin
      rc[i] = 0;
      rd[i] = '0;
      rm[i] = '0;
    end
  endtask

  // drop_mode: 0 keep valid, 1 drop during READ, 2 random; only on a last service.
  task automatic wait_drain(input int drop_mode);
    bit done;
    int g;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      pio_load = 1'b0;
      if (bus.pio_chipselect && bus.pio_write_n) begin
        g = int'(grant_id);
        if (g < NUM_REQ && remaining[g] == 1) begin
          if (drop_mode == 1 || (drop_mode == 2 && $urandom_range(0, 1) == 1))
            bus.req_valid[g] = 1'b0;
          if ($urandom_range(0, 1) == 1) begin
            bus.req_data[g*DATA_W +: DATA_W] = DATA_W'($urandom);
            bus.req_mask[g*DATA_W +: DATA_W] = DATA_W'($urandom);
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ack[i]) begin
          if (remaining[i] > 0) remaining[i]--;
          if (remaining[i] == 0) bus.req_valid[i] = 1'b0;
        end
      end
      done = (exp_ack.size() == 0);
      for (int i = 0; i < NUM_REQ; i++) if (remaining[i] != 0) done = 1'b0;
    end
    check_output("round_done", {31'd0, done}, 32'd1);
  endtask

  task automatic apply_stimulus(input bit do_load, input logic [DATA_W-1:0] load_val, input int drop_mode);
    @(negedge clk);
    if (do_load) begin
      pio_load     = 1'b1;
      pio_load_val = load_val;
      ref_pio      = load_val;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      remaining[i] = rc[i];
      bus.req_valid[i] = (rc[i] > 0);
      bus.req_data[i*DATA_W +: DATA_W] = rd[i];
      bus.req_mask[i*DATA_W +: DATA_W] = rm[i];
    end
    model_round();
    wait_drain(drop_mode);
  endtask

  // Monitor: every READ/WRITE/ACK the DUT shows is checked against the queues.
  int read_cnt = 0;
  int busy_start = 0;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      read_cnt  = 0;
      prev_busy = 1'b0;
    end else if (mon_enable) begin
      if (busy && !prev_busy) busy_start = cycle;
      if (bus.pio_chipselect && bus.pio_write_n) read_cnt++;
      if (bus.pio_chipselect && !bus.pio_write_n) begin
        if (exp_wr.size() == 0) begin
          check_output("write_unexpected", bus.pio_writedata, 32'hFFFF_FFFF);
        end else begin
          e = exp_wr.pop_front();
          check_output("writedata", bus.pio_writedata, e.wdata);
          check_output("grant_id", {29'd0, grant_id}, 32'(e.idx));
          check_output("reads_before_write", 32'(read_cnt), 32'd1);
          check_output("pio_address", {30'd0, bus.pio_address}, 32'd0);
        end
        read_cnt = 0;
      end else begin
        check_output("writedata_idle", bus.pio_writedata, 32'd0);
      end
      if (bus.req_ack != '0) begin
        if (exp_ack.size() == 0) begin
          check_output("ack_unexpected", 32'(bus.req_ack), 32'd0);
        end else begin
          e = exp_ack.pop_front();
          check_output("req_ack", 32'(bus.req_ack), 32'd1 << e.idx);
          check_output("ack_latency", 32'(cycle - busy_start), 32'd2);
          check_output("out_port", {{(32-DATA_W){1'b0}}, pio_reg}, e.wdata);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    bit found;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_mask  = '0;
    for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
    clear_round();

    pio_load     = 1'b1;
    pio_load_val = 10'h155;
    ref_pio      = 10'h155;
    repeat (3) @(negedge clk);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_cs", {31'd0, bus.pio_chipselect}, 32'd0);
    check_output("rst_write_n", {31'd0, bus.pio_write_n}, 32'd1);
    check_output("rst_wdata", bus.pio_writedata, 32'd0);
    check_output("rst_ack", 32'(bus.req_ack), 32'd0);
    check_output("rst_grant", {29'd0, grant_id}, 32'd0);
    pio_load = 1'b0;
    reset_n  = 1'b1;

    // Reset in the middle of WRITE abandons the transaction without an ack.
    @(negedge clk);
    rd[1] = 10'h0AA;
    rm[1] = 10'h0FF;
    bus.req_data[1*DATA_W +: DATA_W] = rd[1];
    bus.req_mask[1*DATA_W +: DATA_W] = rm[1];
    bus.req_valid[1] = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.pio_chipselect && !bus.pio_write_n) found = 1'b1;
    end
    check_output("reach_write", {31'd0, found}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("midrst_cs", {31'd0, bus.pio_chipselect}, 32'd0);
    check_output("midrst_write_n", {31'd0, bus.pio_write_n}, 32'd1);
    check_output("midrst_busy", {31'd0, busy}, 32'd0);
    check_output("midrst_wdata", bus.pio_writedata, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_output("midrst_no_ack", 32'(bus.req_ack), 32'd0);
    end
    check_output("midrst_pio", {22'd0, pio_reg}, 32'h155);
    rc[1] = 1;
    remaining[1] = 1;
    model_round();
    mon_enable = 1'b1;
    reset_n = 1'b1;
    wait_drain(0);

    clear_round();
    rc[0] = 1; rd[0] = 10'h3FF; rm[0] = 10'h00F;
    apply_stimulus(1'b1, 10'h000, 0);

    clear_round();
    rc[2] = 1; rd[2] = 10'h0F0; rm[2] = 10'h3C0;
    apply_stimulus(1'b1, 10'h2A5, 0);

    clear_round();
    rc[3] = 1; rd[3] = 10'h001; rm[3] = 10'h001;
    apply_stimulus(1'b0, '0, 0);

    clear_round();
    rc[1] = 1; rd[1] = 10'h155; rm[1] = 10'h0F0;
    rc[3] = 1; rd[3] = 10'h2AA; rm[3] = 10'h30F;
    apply_stimulus(1'b0, '0, 0);

    clear_round();
    rc[0] = 1; rd[0] = 10'h3FF; rm[0] = 10'h003;
    rc[1] = 1; rd[1] = 10'h000; rm[1] = 10'h001;
    apply_stimulus(1'b0, '0, 0);

    clear_round();
    rc[0] = 3; rd[0] = 10'h111; rm[0] = 10'h333;
    rc[2] = 2; rd[2] = 10'h2CC; rm[2] = 10'h0CC;
    apply_stimulus(1'b0, '0, 0);

    clear_round();
    rc[1] = 1; rd[1] = 10'h3FF; rm[1] = 10'h000;
    apply_stimulus(1'b1, 10'h1B6, 1);

    for (int r = 0; r < 25; r++) begin
      clear_round();
      for (int i = 0; i < NUM_REQ; i++) begin
        rc[i] = int'($urandom_range(0, 2));
        rd[i] = DATA_W'($urandom);
        rm[i] = DATA_W'($urandom);
      end
      rc[$urandom_range(0, NUM_REQ-1)] = 1;
      apply_stimulus($urandom_range(0, 1) == 1, DATA_W'($urandom), 2);
    end

    repeat (3) @(negedge clk);
    check_output("queue_wr_empty", 32'(exp_wr.size()), 32'd0);
    check_output("queue_ack_empty", 32'(exp_ack.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
